// File: rtl/cpu_step_ctrl_if.sv
// Port bundle for cpu_step_ctrl: mode/divisor/button/breakpoint controls in,
// pipeline enable and status out. master = controller side, slave = board side.
interface cpu_step_ctrl_if #(
    parameter int DIV_W = 27
);
    logic [1:0]       mode;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             step_btn;
    logic [7:0]       burst_len;
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             cpu_ce;
    logic             cpu_clk_slow;
    logic [2:0]       state;
    logic             halted;
    logic [31:0]      tick_count;

    modport master (
        input  mode, div_load, div_value, step_btn, burst_len, pc, bp_addr, bp_valid,
        output cpu_ce, cpu_clk_slow, state, halted, tick_count
    );

    modport slave (
        output mode, div_load, div_value, step_btn, burst_len, pc, bp_addr, bp_valid,
        input  cpu_ce, cpu_clk_slow, state, halted, tick_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Pipeline clock-enable generator: RUN at a divided rate, STEP per debounced press,
// BURST of N enables per press. PC breakpoint freeze enabled by STEP_CTRL_BREAKPOINT_EN.
module cpu_step_ctrl #(
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int DEB_W       = 20
) (
    input logic             clk,
    input logic             reset,
    cpu_step_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_HALT      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_BURST     = 3'd3,
        ST_BREAK     = 3'd4
    } state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [7:0]       burst_q, burst_d;
    logic             ce_q, ce_d;
    logic             slow_q, slow_d;
    logic [31:0]      tick_count_q, tick_count_d;

    logic press;
    logic counting;
    logic terminal;
    logic tick;
    logic bp_hit;

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{bus.pc, bus.bp_addr, bus.bp_valid};
    assign bp_hit    = 1'b0;
`endif

    // A press is the accepted level flipping 0->1 after DEB_CYCLES differing samples.
    always_comb begin
        sync1_d   = bus.step_btn;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press     = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
                press = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        div_d = div_q;
        if (bus.div_load) begin
            div_d = (bus.div_value == '0) ? DIV_W'(1) : bus.div_value;
        end
        counting = (state_q == ST_RUN) || (state_q == ST_BURST);
        terminal = (cnt_q == div_q - DIV_W'(1));
        tick     = counting && !bus.div_load && terminal;
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        ce_d    = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (bus.mode == 2'b01) begin
                    state_d = ST_RUN;
                end else if (bus.mode[1]) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (bus.mode != 2'b01) begin
                    state_d = (bus.mode == 2'b00) ? ST_HALT : ST_STEP_WAIT;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                    end else begin
                        ce_d = 1'b1;
                    end
                end
            end
            ST_STEP_WAIT: begin
                if (bus.mode == 2'b00) begin
                    state_d = ST_HALT;
                end else if (bus.mode == 2'b01) begin
                    state_d = ST_RUN;
                end else if (press) begin
                    if (bus.mode == 2'b10) begin
                        ce_d = 1'b1;
                    end else begin
                        burst_d = (bus.burst_len == 8'd0) ? 8'd1 : bus.burst_len;
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (bus.mode != 2'b11) begin
                    state_d = (bus.mode == 2'b00) ? ST_HALT : ST_STEP_WAIT;
                    burst_d = 8'd0;
                end else if (tick) begin
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                        burst_d = 8'd0;
                    end else begin
                        ce_d    = 1'b1;
                        burst_d = burst_q - 8'd1;
                        if (burst_q == 8'd1) begin
                            state_d = ST_STEP_WAIT;
                        end
                    end
                end
            end
            // Only a press advances the core here; the breakpoint is not re-armed for it.
            ST_BREAK: begin
                if (bus.mode == 2'b00) begin
                    state_d = ST_HALT;
                end else if (press) begin
                    ce_d = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Counter only advances while staying in RUN/BURST, so every entry starts from 0.
    always_comb begin
        cnt_d = '0;
        if (counting && (state_d == state_q) && !bus.div_load && !terminal) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        slow_d       = slow_q ^ ce_d;
        tick_count_d = tick_count_q + {31'b0, ce_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HALT;
            div_q        <= DIV_W'(DEFAULT_DIV);
            cnt_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_q        <= 1'b0;
            deb_cnt_q    <= '0;
            burst_q      <= 8'd0;
            ce_q         <= 1'b0;
            slow_q       <= 1'b0;
            tick_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_cnt_q    <= deb_cnt_d;
            burst_q      <= burst_d;
            ce_q         <= ce_d;
            slow_q       <= slow_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign bus.cpu_ce       = ce_q;
    assign bus.cpu_clk_slow = slow_q;
    assign bus.state        = state_q;
    assign bus.halted       = (state_q == ST_HALT) || (state_q == ST_STEP_WAIT) || (state_q == ST_BREAK);
    assign bus.tick_count   = tick_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEFAULT_DIV=6 and DEB_CYCLES=8 so every mode
// fits in a few hundred cycles; breakpoint expectations follow STEP_CTRL_BREAKPOINT_EN.
module tb_cpu_step_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cpu_step_ctrl_if #(.DIV_W(27)) bus ();

    cpu_step_ctrl #(
        .DIV_W(27),
        .DEFAULT_DIV(6),
        .DEB_CYCLES(8),
        .DEB_W(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic btn);
        bus.mode     = m;
        bus.step_btn = btn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] mask;
        logic        prev_slow;
        int          ces;
        int          first;
        int          toggles;
        int          st10;
        int          st16;

        reset         = 1'b1;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        bus.burst_len = 8'd0;
        bus.pc        = 32'd0;
        bus.bp_addr   = 32'd0;
        bus.bp_valid  = 1'b0;
        applyStimulus(2'b00, 1'b0);
        cyc();
        cyc();
        checkOutput("reset_ce", bus.cpu_ce, 0);
        checkOutput("reset_slow", bus.cpu_clk_slow, 0);
        checkOutput("reset_state", bus.state, 0);
        checkOutput("reset_halted", bus.halted, 1);
        checkOutput("reset_ticks", bus.tick_count, 0);

        $display("[TB] RUN with divisor 4");
        reset         = 1'b0;
        bus.div_load  = 1'b1;
        bus.div_value = 27'd4;
        cyc();
        bus.div_load = 1'b0;
        applyStimulus(2'b01, 1'b0);
        ces = 0; first = -1; toggles = 0; prev_slow = bus.cpu_clk_slow;
        for (int i = 1; i <= 21; i++) begin
            cyc();
            if (bus.cpu_ce) begin
                ces++;
                if (first < 0) first = i;
            end
            if (bus.cpu_clk_slow !== prev_slow) toggles++;
            prev_slow = bus.cpu_clk_slow;
        end
        checkOutput("run4_first", first, 5);
        checkOutput("run4_pulses", ces, 5);
        checkOutput("run4_toggles", toggles, 5);
        checkOutput("run4_ticks", bus.tick_count, 5);
        checkOutput("run4_state", bus.state, 1);
        checkOutput("run4_halted", bus.halted, 0);

        $display("[TB] divisor change to 3 mid-RUN");
        cyc();
        bus.div_load  = 1'b1;
        bus.div_value = 27'd3;
        mask = '0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            if (i == 1) bus.div_load = 1'b0;
            mask[i-1] = bus.cpu_ce;
        end
        checkOutput("div3_pattern", mask, 32'b1001000);

        $display("[TB] divisor 0 behaves as 1, then HALT");
        bus.div_load  = 1'b1;
        bus.div_value = 27'd0;
        mask = '0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 1) bus.div_load = 1'b0;
            mask[i-1] = bus.cpu_ce;
        end
        checkOutput("div1_pattern", mask, 32'b11110);
        applyStimulus(2'b00, 1'b0);
        cyc();
        checkOutput("halt_ce_fall", bus.cpu_ce, 0);
        checkOutput("halt_state", bus.state, 0);
        checkOutput("halt_halted", bus.halted, 1);
        repeat (3) cyc();
        checkOutput("halt_ticks_frozen", bus.tick_count, 11);
        checkOutput("halt_slow", bus.cpu_clk_slow, 1);

        $display("[TB] STEP with bouncing button");
        applyStimulus(2'b10, 1'b0);
        cyc();
        checkOutput("step_enter_state", bus.state, 2);
        applyStimulus(2'b10, 1'b1);
        ces = 0; first = -1;
        for (int i = 1; i <= 34; i++) begin
            cyc();
            if (i == 1) applyStimulus(2'b10, 1'b0);
            if (i == 2) applyStimulus(2'b10, 1'b1);
            if (i == 21) applyStimulus(2'b10, 1'b0);
            if (bus.cpu_ce) begin
                ces++;
                if (first < 0) first = i;
            end
        end
        checkOutput("step_pulses", ces, 1);
        checkOutput("step_first", first, 12);
        checkOutput("step_state", bus.state, 2);
        checkOutput("step_halted", bus.halted, 1);
        checkOutput("step_ticks", bus.tick_count, 12);

        $display("[TB] BURST of 3 at divisor 2");
        bus.div_load  = 1'b1;
        bus.div_value = 27'd2;
        bus.burst_len = 8'd3;
        applyStimulus(2'b11, 1'b0);
        cyc();
        bus.div_load = 1'b0;
        checkOutput("burst_wait_state", bus.state, 2);
        applyStimulus(2'b11, 1'b1);
        mask = '0; st10 = -1; st16 = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            mask[i-1] = bus.cpu_ce;
            if (i == 10) st10 = int'(bus.state);
            if (i == 16) st16 = int'(bus.state);
        end
        checkOutput("burst_pattern", mask, 32'h0000A800);
        checkOutput("burst_active_state", st10, 3);
        checkOutput("burst_done_state", st16, 2);
        checkOutput("burst_ticks", bus.tick_count, 15);

        $display("[TB] reset during BURST");
        applyStimulus(2'b11, 1'b0);
        repeat (12) cyc();
        bus.burst_len = 8'd5;
        applyStimulus(2'b11, 1'b1);
        repeat (12) cyc();
        checkOutput("burst2_ce", bus.cpu_ce, 1);
        checkOutput("burst2_state", bus.state, 3);
        reset = 1'b1;
        applyStimulus(2'b11, 1'b0);
        cyc();
        checkOutput("rst_ce", bus.cpu_ce, 0);
        checkOutput("rst_slow", bus.cpu_clk_slow, 0);
        checkOutput("rst_state", bus.state, 0);
        checkOutput("rst_halted", bus.halted, 1);
        checkOutput("rst_ticks", bus.tick_count, 0);

        $display("[TB] RUN at default divisor after reset");
        reset = 1'b0;
        applyStimulus(2'b01, 1'b0);
        repeat (6) cyc();
        checkOutput("default_div_early", bus.cpu_ce, 0);
        cyc();
        checkOutput("default_div_pulse", bus.cpu_ce, 1);
        checkOutput("default_div_ticks", bus.tick_count, 1);

        $display("[TB] breakpoint at pc 0x10");
        bus.pc       = 32'h10;
        bus.bp_addr  = 32'h10;
        bus.bp_valid = 1'b1;
        mask = '0;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            mask[i-1] = bus.cpu_ce;
        end
`ifdef STEP_CTRL_BREAKPOINT_EN
        checkOutput("bp_suppressed", mask, 32'b0);
        checkOutput("bp_state", bus.state, 4);
        checkOutput("bp_halted", bus.halted, 1);
        applyStimulus(2'b01, 1'b1);
        mask = '0;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            mask[i-1] = bus.cpu_ce;
        end
        checkOutput("bp_press_pattern", mask, 32'h00000200);
        checkOutput("bp_press_state", bus.state, 4);
        checkOutput("bp_ticks", bus.tick_count, 2);
`else
        checkOutput("nobp_pattern", mask, 32'b0100000);
        checkOutput("nobp_state", bus.state, 1);
        checkOutput("nobp_ticks", bus.tick_count, 2);
`endif
        applyStimulus(2'b00, 1'b0);
        cyc();
        checkOutput("final_halt_state", bus.state, 0);
        checkOutput("final_halt_ce", bus.cpu_ce, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
